// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : uart_pkg
// Brief  : Shared types and constants for the uart_nibble_tx transmitter:
//          FSM state encoding, idle line level and a counter-width helper.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package uart_pkg;

  // Frame sequencer states. PARITY is only visited when the parity build
  // option (UART_NIBBLE_TX_PARITY_EN) is enabled.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Level of the serial line when nothing is being sent.
  localparam logic TXD_IDLE = 1'b1;

  // Bits needed to hold a count of 0..max_count, never less than one bit.
  function automatic int cnt_width(input int max_count);
    if (max_count < 1) begin
      return 1;
    end
    return $clog2(max_count + 1);
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : uart_baud_tick
// Brief  : Bit-period divider. Counts 0..CLKS_PER_BIT-1 and raises a
//          one-cycle tick on the last count of each bit period. A clear
//          input holds the count at zero so a new period starts cleanly.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = cnt_width(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // Free-running bit-period counter, wrapped only by its own terminal count
  // or by the explicit clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || (count == LAST_COUNT)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  // Tick marks the final cycle of the current bit period; it is suppressed
  // while cleared so a held-off counter never advances the sequencer.
  assign tick = (count == LAST_COUNT) && !clear;

endmodule : uart_baud_tick
`default_nettype wire

// File: rtl/uart_nibble_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : uart_nibble_tx
// Brief  : UART transmitter for a DATA_W-bit word accepted by valid/ready.
//          Frame: start bit (0), data LSB first, optional even parity,
//          STOP_BITS stop bits (1). Each bit lasts CLKS_PER_BIT cycles.
//          Build option: define UART_NIBBLE_TX_PARITY_EN to insert an even
//          parity bit between the data bits and the stop bit(s).
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module uart_nibble_tx
  import uart_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              txd,
  output logic              busy
);

  localparam int BIT_CW  = cnt_width(DATA_W - 1);
  localparam int STOP_CW = cnt_width(STOP_BITS - 1);
  localparam logic [BIT_CW-1:0]  LAST_BIT  = BIT_CW'(DATA_W - 1);
  localparam logic [STOP_CW-1:0] LAST_STOP = STOP_CW'(STOP_BITS - 1);

  tx_state_t           state;
  logic [DATA_W-1:0]   shift;
  logic [DATA_W-1:0]   shift_next;
  logic [BIT_CW-1:0]   bit_idx;
  logic [STOP_CW-1:0]  stop_idx;
  logic                baud_clear;
  logic                tick;
`ifdef UART_NIBBLE_TX_PARITY_EN
  logic                parity;
`endif

  // The bit timer is held at zero in IDLE so START always gets a full
  // period; every other state change happens on a tick, where the timer
  // wraps to zero by itself.
  assign baud_clear = (state == IDLE);

  // Word as it will look after the current data bit has been sent.
  assign shift_next = shift >> 1;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (baud_clear),
    .tick  (tick)
  );

  // Frame sequencer. txd, ready and busy are registered and set together
  // with the state they belong to, so txd drops on the very first cycle
  // after the handshake edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= '0;
      bit_idx  <= '0;
      stop_idx <= '0;
      txd      <= TXD_IDLE;
      ready    <= 1'b1;
      busy     <= 1'b0;
`ifdef UART_NIBBLE_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (valid && ready) begin
            shift  <= data;
`ifdef UART_NIBBLE_TX_PARITY_EN
            // Parity comes from the word as presented, not the shifter.
            parity <= ^data;
`endif
            state  <= START;
            txd    <= 1'b0;
            ready  <= 1'b0;
            busy   <= 1'b1;
          end
        end

        START: begin
          if (tick) begin
            state   <= DATA;
            bit_idx <= '0;
            txd     <= shift[0];
          end
        end

        DATA: begin
          if (tick) begin
            shift <= shift_next;
            if (bit_idx == LAST_BIT) begin
              bit_idx <= '0;
`ifdef UART_NIBBLE_TX_PARITY_EN
              state   <= PARITY;
              txd     <= parity;
`else
              state    <= STOP;
              stop_idx <= '0;
              txd      <= TXD_IDLE;
`endif
            end else begin
              bit_idx <= bit_idx + BIT_CW'(1);
              txd     <= shift_next[0];
            end
          end
        end

`ifdef UART_NIBBLE_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state    <= STOP;
            stop_idx <= '0;
            txd      <= TXD_IDLE;
          end
        end
`endif

        STOP: begin
          if (tick) begin
            if (stop_idx == LAST_STOP) begin
              state    <= IDLE;
              stop_idx <= '0;
              ready    <= 1'b1;
              busy     <= 1'b0;
              txd      <= TXD_IDLE;
            end else begin
              stop_idx <= stop_idx + STOP_CW'(1);
            end
          end
        end

        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          txd   <= TXD_IDLE;
        end
      endcase
    end
  end

endmodule : uart_nibble_tx
`default_nettype wire
